// File: rtl/cpc_bus_pkg.sv
// cpc_bus_pkg: shared cycle encodings, sampled-bus record and expansion-port constants
package cpc_bus_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_MPEND, ST_MRD, ST_MWR, ST_OPF, ST_RFSH, ST_IORD, ST_IOWR, ST_INTA
    } state_t;
    typedef enum logic [2:0] {
        CYC_IDLE, CYC_MRD, CYC_MWR, CYC_OPF, CYC_RFSH, CYC_IORD, CYC_IOWR, CYC_INTA
    } cyc_t;
    typedef struct packed {
        logic       mreq_b;
        logic       iorq_b;
        logic       rd_b;
        logic       wr_b;
        logic       m1_b;
        logic       rfsh_b;
        logic       adr15;
        logic       adr14;
        logic       adr8;
        logic [7:0] data;
        logic       low_port_sel;
    } bus_t;
    localparam logic [1:0] CFG_TAG   = 2'b11;
    localparam logic       CFG_ADR15 = 1'b0;
    localparam bus_t       BUS_IDLE  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    // Three output bits cannot hold nine states: a memory cycle whose direction is
    // still undecided (MPEND) is reported as IDLE until rd_b or wr_b resolves it.
    function automatic cyc_t cyc_code(state_t s);
        case (s)
            ST_MRD:  return CYC_MRD;
            ST_MWR:  return CYC_MWR;
            ST_OPF:  return CYC_OPF;
            ST_RFSH: return CYC_RFSH;
            ST_IORD: return CYC_IORD;
            ST_IOWR: return CYC_IOWR;
            ST_INTA: return CYC_INTA;
            default: return CYC_IDLE;
        endcase
    endfunction
endpackage

// File: rtl/cpc_bus_cycle_decoder_if.sv
// cpc_bus_cycle_decoder_if: raw Z80 bus strobes, address bits, data and port select
interface cpc_bus_cycle_decoder_if;
    logic       mreq_b;
    logic       iorq_b;
    logic       rd_b;
    logic       wr_b;
    logic       m1_b;
    logic       rfsh_b;
    logic       adr15;
    logic       adr14;
    logic       adr8;
    logic [7:0] data;
    logic       low_port_sel;
    modport master (output mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr14, adr8, data, low_port_sel);
    modport slave  (input  mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr14, adr8, data, low_port_sel);
endinterface

// File: rtl/cpc_bus_sampler.sv
// cpc_bus_sampler: single register stage (S) for every bus input
module cpc_bus_sampler
    import cpc_bus_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    cpc_bus_cycle_decoder_if.slave        bus,
    output bus_t                          o_s
);
    // capture the bus every edge; reset parks the strobes inactive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_s <= BUS_IDLE;
        else o_s <= '{bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.m1_b, bus.rfsh_b,
                      bus.adr15, bus.adr14, bus.adr8, bus.data, bus.low_port_sel};
    end
endmodule

// File: rtl/cpc_bus_cycle_decoder.sv
// cpc_bus_cycle_decoder: classifies Z80 bus cycles, times them and captures expansion-port writes
module cpc_bus_cycle_decoder
    import cpc_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 12,
    parameter int CNT_W          = 4
)(
    input  logic             clk,
    input  logic             reset,
    cpc_bus_cycle_decoder_if.slave bus,
    output logic [2:0]       cyc_type,
    output logic             mrd_cyc,
    output logic             mwr_cyc,
    output logic             cfg_wr_stb,
    output logic [5:0]       cfg_data,
    output logic             cfg_sel,
    output logic [CNT_W-1:0] cyc_len,
    output logic             cyc_end_stb,
    output logic             timeout_stb,
    output logic             bus_err_stb
);
    bus_t             w_s;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_mem, w_io, w_enter, w_exit, w_cfg_hit, w_unused;

    cpc_bus_sampler u_sampler (.clk(clk), .reset(reset), .bus(bus), .o_s(w_s));

    assign w_unused  = w_s.adr14;
    assign w_mem     = !w_s.mreq_b;
    assign w_io      = !w_s.iorq_b;
    assign w_enter   = r_state == ST_IDLE && w_next != ST_IDLE;
    assign w_exit    = r_state != ST_IDLE && w_next == ST_IDLE;
    assign w_cfg_hit = w_enter && w_next == ST_IOWR && w_s.adr15 == CFG_ADR15 && w_s.data[7:6] == CFG_TAG;
    assign w_cnt_nxt = w_next == ST_IDLE ? '0 : w_enter ? CNT_W'(1) : &r_cnt ? r_cnt : r_cnt + 1'b1;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // next state from the sampled bus; active cycles only end on a high strobe sample
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:
                w_next = (w_mem && w_io)                   ? ST_IDLE  :
                         (w_mem && !w_s.rfsh_b)            ? ST_RFSH  :
                         (w_mem && !w_s.m1_b)              ? ST_OPF   :
                         (w_mem && !w_s.rd_b)              ? ST_MRD   :
                         (w_mem && w_s.rd_b && w_s.wr_b)   ? ST_MPEND :
                         (w_io && !w_s.m1_b)               ? ST_INTA  :
                         (w_io && !w_s.wr_b)               ? ST_IOWR  :
                         (w_io && !w_s.rd_b)               ? ST_IORD  : ST_IDLE;
            ST_MPEND:
                w_next = !w_s.wr_b ? ST_MWR : !w_s.rd_b ? ST_MRD : w_s.mreq_b ? ST_IDLE : ST_MPEND;
            ST_IORD, ST_IOWR, ST_INTA:
                w_next = w_s.iorq_b ? ST_IDLE : r_state;
            default:
                w_next = w_s.mreq_b ? ST_IDLE : r_state;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        cyc_type = cyc_code(r_state);
        mrd_cyc  = r_state == ST_MRD;
        mwr_cyc  = r_state == ST_MWR;
    end

    // cycle timing, event strobes and the expansion-register capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            cyc_len     <= '0;
            cyc_end_stb <= 1'b0;
            timeout_stb <= 1'b0;
            bus_err_stb <= 1'b0;
            cfg_wr_stb  <= 1'b0;
            cfg_data    <= '0;
            cfg_sel     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            cyc_len     <= w_exit ? r_cnt : cyc_len;
            cyc_end_stb <= w_exit;
            timeout_stb <= w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES) && r_cnt != CNT_W'(TIMEOUT_CYCLES);
            bus_err_stb <= r_state == ST_IDLE && w_mem && w_io;
            cfg_wr_stb  <= w_cfg_hit;
            cfg_data    <= w_cfg_hit ? w_s.data[5:0] : cfg_data;
            cfg_sel     <= w_cfg_hit ? (w_s.low_port_sel ? !w_s.adr8 : w_s.adr8) : cfg_sel;
        end
    end
endmodule

// File: tb/tb_cpc_bus_cycle_decoder.sv
// tb_cpc_bus_cycle_decoder: directed bus sequences checked against a cycle-level model every clock
module tb_cpc_bus_cycle_decoder;
    localparam int TO = 12;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    cyc_type;
    logic          mrd_cyc, mwr_cyc, cfg_wr_stb, cfg_sel, cyc_end_stb, timeout_stb, bus_err_stb;
    logic [5:0]    cfg_data;
    logic [CW-1:0] cyc_len;
    int            n_cmp = 0, n_bad = 0;
    int            n_mwr = 0, n_mrd = 0, n_end = 0, n_to = 0, n_err = 0, n_cfg = 0;
    int            b_mwr, b_mrd, b_end, b_to, b_err, b_cfg;

    cpc_bus_cycle_decoder_if bus_if ();

    cpc_bus_cycle_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus_if),
        .cyc_type(cyc_type), .mrd_cyc(mrd_cyc), .mwr_cyc(mwr_cyc),
        .cfg_wr_stb(cfg_wr_stb), .cfg_data(cfg_data), .cfg_sel(cfg_sel),
        .cyc_len(cyc_len), .cyc_end_stb(cyc_end_stb),
        .timeout_stb(timeout_stb), .bus_err_stb(bus_err_stb)
    );

    always #5 clk = ~clk;

    // model: the sampled bus one edge behind, the cycle name and its true clock count
    logic       s_mreq, s_iorq, s_rd, s_wr, s_m1, s_rfsh, s_a15, s_a8, s_lps;
    logic [7:0] s_dat;
    string      kind = "IDLE";
    int         clocks = 0;
    int         e_len = 0, e_cdata = 0, e_csel = 0;
    bit         e_end, e_to, e_err, e_cfg;

    function automatic int code_of(string k);
        if (k == "MRD")  return 1;
        if (k == "MWR")  return 2;
        if (k == "OPF")  return 3;
        if (k == "RFSH") return 4;
        if (k == "IORD") return 5;
        if (k == "IOWR") return 6;
        if (k == "INTA") return 7;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            kind = "IDLE"; clocks = 0; e_len = 0; e_cdata = 0; e_csel = 0;
            e_end = 0; e_to = 0; e_err = 0; e_cfg = 0;
            {s_mreq, s_iorq, s_rd, s_wr, s_m1, s_rfsh} = 6'h3F;
            {s_a15, s_a8, s_lps, s_dat} = '0;
        end else begin
            e_end = 0; e_err = 0; e_cfg = 0;
            if (kind == "IDLE") begin
                if (!s_mreq && !s_iorq) e_err = 1;
                else if (!s_mreq) kind = !s_rfsh ? "RFSH" : !s_m1 ? "OPF" : !s_rd ? "MRD" : s_wr ? "MPEND" : "IDLE";
                else if (!s_iorq) kind = !s_m1 ? "INTA" : !s_wr ? "IOWR" : !s_rd ? "IORD" : "IDLE";
                if (kind == "IOWR" && !s_a15 && s_dat[7:6] == 2'b11) begin
                    e_cfg = 1; e_cdata = int'(s_dat[5:0]); e_csel = int'(s_lps ? !s_a8 : s_a8);
                end
                clocks = kind == "IDLE" ? 0 : 1;
            end else begin
                if (kind == "MPEND" && !s_wr) kind = "MWR";
                else if (kind == "MPEND" && !s_rd) kind = "MRD";
                else if ((kind == "IORD" || kind == "IOWR" || kind == "INTA") ? s_iorq : s_mreq) begin
                    e_len = clocks > 15 ? 15 : clocks; e_end = 1; kind = "IDLE";
                end
                clocks = kind == "IDLE" ? 0 : clocks + 1;
            end
            e_to = kind != "IDLE" && clocks == TO;
            {s_mreq, s_iorq, s_rd, s_wr, s_m1, s_rfsh} =
                {bus_if.mreq_b, bus_if.iorq_b, bus_if.rd_b, bus_if.wr_b, bus_if.m1_b, bus_if.rfsh_b};
            {s_a15, s_a8, s_lps, s_dat} = {bus_if.adr15, bus_if.adr8, bus_if.low_port_sel, bus_if.data};
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // compare every output against the model mid-cycle and tally observed pulses
    always @(negedge clk) begin
        chk("cyc_type", int'(cyc_type), code_of(kind));
        chk("mrd_cyc", int'(mrd_cyc), int'(kind == "MRD"));
        chk("mwr_cyc", int'(mwr_cyc), int'(kind == "MWR"));
        chk("cyc_end_stb", int'(cyc_end_stb), int'(e_end));
        chk("cyc_len", int'(cyc_len), e_len);
        chk("timeout_stb", int'(timeout_stb), int'(e_to));
        chk("bus_err_stb", int'(bus_err_stb), int'(e_err));
        chk("cfg_wr_stb", int'(cfg_wr_stb), int'(e_cfg));
        chk("cfg_data", int'(cfg_data), e_cdata);
        chk("cfg_sel", int'(cfg_sel), e_csel);
        n_mwr += int'(mwr_cyc); n_mrd += int'(mrd_cyc); n_end += int'(cyc_end_stb);
        n_to += int'(timeout_stb); n_err += int'(bus_err_stb); n_cfg += int'(cfg_wr_stb);
    end

    task automatic strobes(logic mreq, logic iorq, logic rd, logic wr, logic m1, logic rfsh, int n);
        {bus_if.mreq_b, bus_if.iorq_b, bus_if.rd_b, bus_if.wr_b, bus_if.m1_b, bus_if.rfsh_b} = {mreq, iorq, rd, wr, m1, rfsh};
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(int n);
        strobes(1, 1, 1, 1, 1, 1, n);
    endtask

    task automatic mark;
        b_mwr = n_mwr; b_mrd = n_mrd; b_end = n_end; b_to = n_to; b_err = n_err; b_cfg = n_cfg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus_if.mreq_b, bus_if.iorq_b, bus_if.rd_b, bus_if.wr_b, bus_if.m1_b, bus_if.rfsh_b} = 6'h3F;
        {bus_if.adr15, bus_if.adr14, bus_if.adr8, bus_if.low_port_sel} = 4'b0000;
        bus_if.data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset cyc_type", int'(cyc_type), 0);
        chk("reset cyc_len", int'(cyc_len), 0);
        chk("reset cfg_data", int'(cfg_data), 0);
        reset = 1'b0;
        idle(3);

        mark;
        strobes(0, 1, 1, 1, 1, 1, 1);
        strobes(0, 1, 1, 0, 1, 1, 2);
        idle(4);
        chk("mwr clocks", n_mwr - b_mwr, 2);
        chk("mwr end pulses", n_end - b_end, 1);
        chk("mwr cyc_len", int'(cyc_len), 3);

        mark;
        bus_if.adr15 = 0; bus_if.adr8 = 1; bus_if.data = 8'hC5; bus_if.low_port_sel = 0;
        strobes(1, 0, 1, 0, 1, 1, 3);
        idle(3);
        chk("cfg pulses C5", n_cfg - b_cfg, 1);
        chk("cfg_data C5", int'(cfg_data), 'h05);
        chk("cfg_sel C5", int'(cfg_sel), 1);
        mark;
        bus_if.data = 8'h85;
        strobes(1, 0, 1, 0, 1, 1, 3);
        idle(3);
        chk("cfg pulses 85", n_cfg - b_cfg, 0);
        chk("cfg_data kept", int'(cfg_data), 'h05);

        bus_if.low_port_sel = 1; bus_if.adr8 = 0; bus_if.data = 8'hFA;
        strobes(1, 0, 1, 0, 1, 1, 2);
        idle(3);
        chk("low port sel", int'(cfg_sel), 1);
        chk("low port data", int'(cfg_data), 'h3A);

        mark;
        bus_if.data = 8'hC0;
        strobes(1, 0, 0, 1, 1, 1, 2);
        idle(2);
        strobes(1, 0, 1, 1, 0, 1, 2);
        idle(2);
        strobes(0, 1, 0, 1, 0, 1, 2);
        idle(1);
        strobes(0, 1, 1, 1, 1, 0, 2);
        idle(2);
        strobes(0, 1, 0, 1, 1, 1, 3);
        idle(3);
        chk("no cfg in IORD/INTA/mem", n_cfg - b_cfg, 0);
        chk("five cycle ends", n_end - b_end, 5);

        mark;
        strobes(0, 1, 0, 1, 1, 1, 20);
        idle(3);
        chk("timeout pulses", n_to - b_to, 1);
        chk("timeout mrd clocks", n_mrd - b_mrd, 20);
        chk("timeout cyc_len", int'(cyc_len), 15);

        mark;
        strobes(0, 0, 0, 1, 1, 1, 1);
        idle(3);
        chk("contention err", n_err - b_err, 1);
        chk("contention ends", n_end - b_end, 0);

        mark;
        bus_if.low_port_sel = 0; bus_if.adr8 = 1; bus_if.data = 8'hC1;
        strobes(1, 0, 1, 0, 1, 1, 3);
        chk("iowr before reset", int'(cyc_type), 6);
        #2 reset = 1'b1;
        #1;
        chk("reset cyc_type async", int'(cyc_type), 0);
        chk("reset cfg_data async", int'(cfg_data), 0);
        chk("reset cfg_sel async", int'(cfg_sel), 0);
        chk("reset cyc_len async", int'(cyc_len), 0);
        @(negedge clk);
        strobes(1, 0, 1, 0, 1, 1, 1);
        idle(1);
        reset = 1'b0;
        idle(2);
        chk("no end on reset", n_end - b_end, 0);
        strobes(0, 1, 0, 1, 1, 1, 2);
        idle(3);
        chk("resume cyc_len", int'(cyc_len), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
